rv_iommu_ds_arbiter: RTL and testbench

- Arbiter and sequencer for the IOMMU data-structure memory port.
- Shares one downstream memory request channel between the internal requesters: DDT walker, PDT walker, page-table walker, CQ/FQ handlers and MSI/MRIF fetch.
- Round-robin grant, one outstanding transaction at a time; the response is routed back to the granted requester.
- Sits between the walker/queue engines and the AXI master adapter that drives the data-structures interface.

---
 rtl/rv_iommu_ds_arbiter_if.sv | 41 ++++
 rtl/rv_iommu_ds_arbiter.sv | 116 +++++++++++
 tb/tb_rv_iommu_ds_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rv_iommu_ds_arbiter_if.sv
// rv_iommu_ds_arbiter_if: requester-side and memory-side channels of the data-structure port arbiter.
interface rv_iommu_ds_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [N_REQ-1:0]            req_valid_i;
  logic [N_REQ-1:0]            req_ready_o;
  logic [N_REQ-1:0]            req_write_i;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [N_REQ*DATA_WIDTH-1:0] req_wdata_i;
  logic [N_REQ-1:0]            rsp_valid_o;
  logic [DATA_WIDTH-1:0]       rsp_data_o;
  logic                        rsp_err_o;
  logic                        mem_req_valid_o;
  logic                        mem_req_ready_i;
  logic                        mem_req_write_o;
  logic [ADDR_WIDTH-1:0]       mem_req_addr_o;
  logic [DATA_WIDTH-1:0]       mem_req_wdata_o;
  logic                        mem_rsp_valid_i;
  logic                        mem_rsp_ready_o;
  logic [DATA_WIDTH-1:0]       mem_rsp_data_i;
  logic                        mem_rsp_err_i;
  logic                        busy_o;
  logic [$clog2(N_REQ)-1:0]    grant_id_o;
  logic                        timeout_o;
  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           mem_req_valid_o, mem_req_write_o, mem_req_addr_o, mem_req_wdata_o,
           mem_rsp_ready_o, busy_o, grant_id_o, timeout_o
  );
  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_err_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           mem_req_valid_o, mem_req_write_o, mem_req_addr_o, mem_req_wdata_o,
           mem_rsp_ready_o, busy_o, grant_id_o, timeout_o
  );
endinterface

// File: rtl/rv_iommu_ds_arbiter.sv
// rv_iommu_ds_arbiter: round-robin single-outstanding arbiter for the IOMMU data-structure memory port.
// Optional watchdog abort enabled by RV_IOMMU_DS_ARB_TIMEOUT_EN.
module rv_iommu_ds_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk_i,
  input logic rst_i,
  rv_iommu_ds_arbiter_if.master bus
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_e;
  state_e                state_q, state_d;
  logic [IW-1:0]         rr_q, rr_d, id_q, id_d, win;
  logic                  found, write_q, write_d, err_q, err_d, to_q, to_d, expire;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [N_REQ-1:0]      ready;
`ifdef RV_IOMMU_DS_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign expire = cnt_q == 16'(TIMEOUT_CYCLES - 1);
  assign cnt_d  = (state_q == ISSUE || state_q == WAIT_RSP) ? cnt_q + 16'd1 : '0;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= N_REQ; i++)
      if (!found && bus.req_valid_i[(int'(rr_q) + i) % N_REQ]) begin
        found = 1'b1;
        win   = IW'((int'(rr_q) + i) % N_REQ);
      end
  end
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    to_d    = 1'b0;
    ready   = '0;
    case (state_q)
      IDLE: if (found) begin
        ready[win] = 1'b1;
        rr_d       = win;
        id_d       = win;
        addr_d     = bus.req_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_d    = bus.req_wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
        write_d    = bus.req_write_i[win];
        state_d    = ISSUE;
      end
      ISSUE: if (bus.mem_req_ready_i) state_d = WAIT_RSP;
      else if (expire) begin
        state_d = RESP;
        to_d    = 1'b1;
        rdata_d = '0;
        err_d   = 1'b1;
      end
      WAIT_RSP: if (bus.mem_rsp_valid_i) begin
        state_d = RESP;
        rdata_d = bus.mem_rsp_data_i;
        err_d   = bus.mem_rsp_err_i;
      end else if (expire) begin
        state_d = RESP;
        to_d    = 1'b1;
        rdata_d = '0;
        err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= IW'(N_REQ - 1);
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  // Grant is combinational from req_valid_i, so mask it while reset holds the FSM.
  assign bus.req_ready_o     = rst_i ? '0 : ready;
  assign bus.rsp_valid_o     = state_q == RESP ? N_REQ'(1) << id_q : '0;
  assign bus.rsp_data_o      = rdata_q;
  assign bus.rsp_err_o       = err_q;
  assign bus.mem_req_valid_o = state_q == ISSUE;
  assign bus.mem_req_write_o = write_q;
  assign bus.mem_req_addr_o  = addr_q;
  assign bus.mem_req_wdata_o = wdata_q;
  assign bus.mem_rsp_ready_o = state_q == WAIT_RSP;
  assign bus.busy_o          = state_q != IDLE;
  assign bus.grant_id_o      = id_q;
  assign bus.timeout_o       = to_q;
endmodule

// File: tb/tb_rv_iommu_ds_arbiter.sv
// tb_rv_iommu_ds_arbiter: directed self-checking bench for the data-structure port arbiter.
module tb_rv_iommu_ds_arbiter;
  localparam int N = 4, AW = 64, DW = 64;
  logic clk = 1'b0, rst = 1'b1;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  rv_iommu_ds_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  rv_iommu_ds_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req_valid_i = '0; bus.req_write_i = '0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus.mem_req_ready_i = 1'b0; bus.mem_rsp_valid_i = 1'b0; bus.mem_rsp_data_i = '0; bus.mem_rsp_err_i = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic run_read(input int r, input logic [DW-1:0] d);
    bus.req_valid_i = 4'b1 << r; bus.mem_req_ready_i = 1'b1;
    tick();
    bus.req_valid_i = '0;
    tick();
    bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_data_i = d;
    tick();
    bus.mem_rsp_valid_i = 1'b0; bus.mem_req_ready_i = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    bus.req_valid_i = '1;
    tick();
    n_checks++; if (bus.req_ready_o !== 4'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b exp 0000", bus.req_ready_o); end
    n_checks++; if (bus.rsp_valid_o !== 4'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b exp 0000", bus.rsp_valid_o); end
    n_checks++; if (bus.mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req_valid: got %b exp 0", bus.mem_req_valid_o); end
    n_checks++; if (bus.mem_rsp_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rsp_ready: got %b exp 0", bus.mem_rsp_ready_o); end
    n_checks++; if (bus.rsp_data_o !== 64'h0 || bus.rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_data: got %h/%b exp 0/0", bus.rsp_data_o, bus.rsp_err_o); end
    n_checks++; if (bus.grant_id_o !== 2'd0 || bus.timeout_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_misc: got id %0d to %b busy %b exp 0 0 0", bus.grant_id_o, bus.timeout_o, bus.busy_o); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL rst_first_prio: got %b exp 0001", bus.req_ready_o); end
    bus.req_valid_i = '0;
    tick();
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_withdraw: got busy %b exp 0", bus.busy_o); end
  endtask

  task automatic test_single_read;
    do_reset();
    bus.req_valid_i = 4'b0100; bus.req_addr_i[2*AW +: AW] = 64'h8000_1000; bus.mem_req_ready_i = 1'b1;
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL sr_ready: got %b exp 0100", bus.req_ready_o); end
    tick();
    bus.req_valid_i = '0;
    n_checks++; if (bus.mem_req_valid_o !== 1'b1 || bus.mem_req_addr_o !== 64'h8000_1000 || bus.mem_req_write_o !== 1'b0) begin n_fail++; $display("FAIL sr_issue: got v %b a %h w %b exp 1 80001000 0", bus.mem_req_valid_o, bus.mem_req_addr_o, bus.mem_req_write_o); end
    n_checks++; if (bus.grant_id_o !== 2'd2 || bus.busy_o !== 1'b1 || bus.req_ready_o !== 4'b0) begin n_fail++; $display("FAIL sr_owner: got id %0d busy %b rdy %b exp 2 1 0000", bus.grant_id_o, bus.busy_o, bus.req_ready_o); end
    tick();
    n_checks++; if (bus.mem_req_valid_o !== 1'b0 || bus.mem_rsp_ready_o !== 1'b1) begin n_fail++; $display("FAIL sr_wait: got v %b rr %b exp 0 1", bus.mem_req_valid_o, bus.mem_rsp_ready_o); end
    bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_data_i = 64'hDEAD_BEEF_0000_0001;
    tick();
    bus.mem_rsp_valid_i = 1'b0; bus.mem_req_ready_i = 1'b0;
    n_checks++; if (bus.rsp_valid_o !== 4'b0100 || bus.rsp_data_o !== 64'hDEAD_BEEF_0000_0001 || bus.rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL sr_resp: got %b %h %b exp 0100 deadbeef00000001 0", bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_err_o); end
    n_checks++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL sr_timeout: got %b exp 0", bus.timeout_o); end
    tick();
    n_checks++; if (bus.rsp_valid_o !== 4'b0 || bus.busy_o !== 1'b0 || bus.rsp_data_o !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL sr_after: got %b busy %b %h exp 0000 0 deadbeef00000001", bus.rsp_valid_o, bus.busy_o, bus.rsp_data_o); end
  endtask

  task automatic test_fairness;
    int exp_id[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int g = 0, multi = 0;
    do_reset();
    bus.req_valid_i = '1; bus.mem_req_ready_i = 1'b1; bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_data_i = 64'h1;
    #1;
    for (int c = 0; c < 40 && g < 8; c++) begin
      if ($countones(bus.req_ready_o) > 1) multi++;
      if (bus.req_ready_o !== 4'b0) begin
        n_checks++; if (bus.req_ready_o !== 4'b1 << exp_id[g]) begin n_fail++; $display("FAIL rr_grant%0d: got %b exp %b", g, bus.req_ready_o, 4'b1 << exp_id[g]); end
        g++;
      end
      tick();
    end
    n_checks++; if (g !== 8) begin n_fail++; $display("FAIL rr_count: got %0d grants exp 8", g); end
    n_checks++; if (multi !== 0) begin n_fail++; $display("FAIL rr_onehot: got %0d multi-grant cycles exp 0", multi); end
    idle_inputs();
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_backpressure;
    int hs = 0, got = 0;
    do_reset();
    bus.req_valid_i = 4'b0010; bus.req_write_i = 4'b0010;
    bus.req_addr_i[AW +: AW] = 64'h1234_5678_9ABC_DEF0; bus.req_wdata_i[DW +: DW] = 64'h0BAD_F00D_CAFE_0001;
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL bp_ready: got %b exp 0010", bus.req_ready_o); end
    tick();
    bus.req_valid_i = '0;
    bus.req_addr_i[AW +: AW] = 64'hFFFF_0000_FFFF_0000; bus.req_wdata_i[DW +: DW] = 64'h1111_2222_3333_4444;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.mem_req_valid_o && bus.mem_req_ready_i) hs++;
      n_checks++; if (bus.mem_req_valid_o !== 1'b1 || bus.mem_req_addr_o !== 64'h1234_5678_9ABC_DEF0 || bus.mem_req_wdata_o !== 64'h0BAD_F00D_CAFE_0001 || bus.mem_req_write_o !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d: got v %b a %h d %h w %b", c, bus.mem_req_valid_o, bus.mem_req_addr_o, bus.mem_req_wdata_o, bus.mem_req_write_o); end
      tick();
    end
    bus.mem_req_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.mem_req_valid_o && bus.mem_req_ready_i) hs++;
      if (bus.rsp_valid_o === 4'b0010) got++;
      bus.mem_rsp_valid_i = bus.mem_rsp_ready_o; bus.mem_rsp_data_i = 64'h77;
      tick();
    end
    idle_inputs();
    n_checks++; if (hs !== 1) begin n_fail++; $display("FAIL bp_handshakes: got %0d exp 1", hs); end
    n_checks++; if (got !== 1) begin n_fail++; $display("FAIL bp_resp: got %0d pulses exp 1", got); end
  endtask

  task automatic test_error_stray;
    do_reset();
    bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_err_i = 1'b1; bus.mem_rsp_data_i = 64'hABCD;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (bus.rsp_valid_o !== 4'b0 || bus.mem_rsp_ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL stray%0d: got rv %b rr %b busy %b exp 0000 0 0", c, bus.rsp_valid_o, bus.mem_rsp_ready_o, bus.busy_o); end
    end
    idle_inputs();
    bus.req_valid_i = 4'b1000; bus.req_write_i = 4'b1000; bus.req_addr_i[3*AW +: AW] = 64'h40; bus.mem_req_ready_i = 1'b1;
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL err_ready: got %b exp 1000", bus.req_ready_o); end
    tick();
    bus.req_valid_i = '0;
    n_checks++; if (bus.mem_req_write_o !== 1'b1 || bus.mem_req_addr_o !== 64'h40) begin n_fail++; $display("FAIL err_issue: got w %b a %h exp 1 40", bus.mem_req_write_o, bus.mem_req_addr_o); end
    tick();
    bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_err_i = 1'b1; bus.mem_rsp_data_i = 64'h55;
    tick();
    bus.mem_rsp_valid_i = 1'b0; bus.mem_rsp_err_i = 1'b0;
    n_checks++; if (bus.rsp_valid_o !== 4'b1000 || bus.rsp_err_o !== 1'b1) begin n_fail++; $display("FAIL err_resp: got %b err %b exp 1000 1", bus.rsp_valid_o, bus.rsp_err_o); end
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.req_valid_i = 4'b0100; bus.req_addr_i[2*AW +: AW] = 64'h900; bus.mem_req_ready_i = 1'b1;
    tick();
    bus.req_valid_i = '0;
    tick();
    n_checks++; if (bus.mem_rsp_ready_o !== 1'b1) begin n_fail++; $display("FAIL rm_wait: got rr %b exp 1", bus.mem_rsp_ready_o); end
    bus.req_valid_i = '1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.mem_rsp_ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_async: got rr %b busy %b mv %b exp 0 0 0", bus.mem_rsp_ready_o, bus.busy_o, bus.mem_req_valid_o); end
    n_checks++; if (bus.grant_id_o !== 2'd0 || bus.req_ready_o !== 4'b0 || bus.mem_req_addr_o !== 64'h0) begin n_fail++; $display("FAIL rm_regs: got id %0d rdy %b a %h exp 0 0000 0", bus.grant_id_o, bus.req_ready_o, bus.mem_req_addr_o); end
    bus.mem_rsp_valid_i = 1'b1;
    tick(); tick();
    n_checks++; if (bus.rsp_valid_o !== 4'b0) begin n_fail++; $display("FAIL rm_no_resp: got %b exp 0000", bus.rsp_valid_o); end
    bus.mem_rsp_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL rm_first: got %b exp 0001", bus.req_ready_o); end
    tick();
    n_checks++; if (bus.grant_id_o !== 2'd0 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL rm_owner: got id %0d busy %b exp 0 1", bus.grant_id_o, bus.busy_o); end
    idle_inputs();
  endtask

`ifdef RV_IOMMU_DS_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int early = 0;
    do_reset();
    run_read(1, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.req_valid_i = 4'b0001; bus.mem_req_ready_i = 1'b1;
    #1;
    n_checks++; if (bus.req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL to_ready: got %b exp 0001", bus.req_ready_o); end
    tick();
    bus.req_valid_i = '0;
    n_checks++; if (bus.mem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL to_issue: got %b exp 1", bus.mem_req_valid_o); end
    for (int c = 2; c <= 16; c++) begin
      tick();
      bus.mem_req_ready_i = 1'b0;
      if (bus.rsp_valid_o !== 4'b0 || bus.timeout_o !== 1'b0) early++;
    end
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL to_early: got %0d early cycles exp 0", early); end
    tick();
    n_checks++; if (bus.rsp_valid_o !== 4'b0001 || bus.timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got rv %b to %b exp 0001 1", bus.rsp_valid_o, bus.timeout_o); end
    n_checks++; if (bus.rsp_err_o !== 1'b1 || bus.rsp_data_o !== 64'h0) begin n_fail++; $display("FAIL to_data: got err %b d %h exp 1 0", bus.rsp_err_o, bus.rsp_data_o); end
    tick();
    n_checks++; if (bus.busy_o !== 1'b0 || bus.timeout_o !== 1'b0) begin n_fail++; $display("FAIL to_idle: got busy %b to %b exp 0 0", bus.busy_o, bus.timeout_o); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "time limit");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_fairness();
    test_backpressure();
    test_error_stray();
    test_reset_mid();
`ifdef RV_IOMMU_DS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
